// File: rtl/tick_arbiter.sv
// Periodic tick generator with a programmable divisor. Each tick is handed to one
// requester, chosen round-robin starting after the previous winner.
module tick_arbiter #(
    parameter int NREQ        = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic [NREQ-1:0]  req,
    output logic             tick,
    output logic [NREQ-1:0]  grant,
    output logic             busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             pend_valid_reg;
    logic             tick_reg;
    logic [NREQ-1:0]  grant_reg;
    logic [IDX_W-1:0] last_reg;

    logic             cfg_accept;
    logic [CNT_W-1:0] cfg_div_clamped;
    logic             at_boundary;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [NREQ-1:0]  win_onehot;
    int               cand;

    assign cfg_accept      = cfg_valid & cfg_ready;
    assign cfg_div_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
    assign at_boundary     = (cnt_reg == (div_reg - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state_reg == RUN);
        cfg_ready = 1'b1;
    end

    // Round-robin search beginning one past the previous winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_reg) + i) % NREQ;
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
        end
    endgenerate

    // Counter, divisor, pending divisor and tick/grant registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg        <= '0;
            div_reg        <= DIV_RST;
            pend_div_reg   <= DIV_RST;
            pend_valid_reg <= 1'b0;
            tick_reg       <= 1'b0;
            grant_reg      <= '0;
            last_reg       <= LAST_RST;
        end else begin
            tick_reg  <= 1'b0;
            grant_reg <= '0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (cfg_accept) div_reg <= cfg_div_clamped;
                end
                RUN: begin
                    if (!enable) begin
                        // Leaving RUN: the newest divisor (pending or just offered) takes over.
                        cnt_reg        <= '0;
                        pend_valid_reg <= 1'b0;
                        if (cfg_accept)          div_reg <= cfg_div_clamped;
                        else if (pend_valid_reg) div_reg <= pend_div_reg;
                    end else if (at_boundary) begin
                        cnt_reg   <= '0;
                        tick_reg  <= 1'b1;
                        grant_reg <= win_onehot;
                        if (win_found)      last_reg <= win_idx;
                        if (pend_valid_reg) div_reg  <= pend_div_reg;
                        // An accept on the boundary itself waits for the following boundary.
                        if (cfg_accept) begin
                            pend_div_reg   <= cfg_div_clamped;
                            pend_valid_reg <= 1'b1;
                        end else begin
                            pend_valid_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cfg_accept) begin
                            pend_div_reg   <= cfg_div_clamped;
                            pend_valid_reg <= 1'b1;
                        end
                    end
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    assign tick  = tick_reg;
    assign grant = grant_reg;

endmodule
